// File: rtl/game_pkg.sv
// Shared game constants, mode encoding and saturating arithmetic helpers.
// Also imported by the renderer, so keep the geometry here in one place.
package game_pkg;

   typedef enum logic [1:0] {
      GM_START = 2'b00,
      GM_GAME  = 2'b01,
      GM_PAUSE = 2'b10,
      GM_END   = 2'b11
   } gamemode_t;

   localparam logic [9:0] SCREEN_W  = 10'd640;
   localparam logic [8:0] SCREEN_H  = 9'd480;
   localparam logic [9:0] PLAYER_X  = 10'd80;
   localparam logic [9:0] PLAYER_W  = 10'd20;
   localparam logic [8:0] PLAYER_H  = 9'd20;
   localparam logic [8:0] PLAYER_Y0 = 9'd200;
   localparam logic [9:0] OBS_W     = 10'd40;
   localparam logic [8:0] OBS_H     = 9'd120;

   function automatic logic [9:0] sat_sub_x(input logic [9:0] a, input logic [9:0] b);
      return (a > b) ? (a - b) : 10'd0;
   endfunction

   function automatic logic [8:0] sat_sub_y(input logic [8:0] a, input logic [8:0] b);
      return (a > b) ? (a - b) : 9'd0;
   endfunction

   function automatic logic [8:0] sat_add_y(input logic [8:0] a, input logic [8:0] b,
                                            input logic [8:0] lim);
      return (a > (lim - b)) ? lim : (a + b);
   endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: valid flag plus rectangle, with scroll, retire and load,
// and an overlap test of the rectangle against the player box.
module obstacle_slot
   import game_pkg::*;
#(
   parameter int unsigned SCROLL_STEP = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       step,
   input  logic       load,
   input  logic [8:0] load_up,
   input  logic [8:0] player_y,
   output logic       free,
   output logic       retire,
   output logic       hit,
   output logic [9:0] left,
   output logic [9:0] right,
   output logic [8:0] up,
   output logic [8:0] down
);

   localparam logic [9:0] STEP_X = 10'(SCROLL_STEP);

   logic       valid_r, valid_s;
   logic [9:0] left_r, left_s, right_r, right_s;
   logic [8:0] up_r, up_s, down_r, down_s;
   logic       retire_s;

   // An invalid slot keeps all-zero coordinates, so the outputs need no masking.
   assign retire_s = valid_r && (right_r <= STEP_X);
   assign retire   = retire_s;
   assign free     = !valid_r || retire_s;
   assign hit      = valid_r
                     && (left_r < (PLAYER_X + PLAYER_W)) && (right_r > PLAYER_X)
                     && (up_r < (player_y + PLAYER_H)) && (down_r > player_y);
   assign left     = left_r;
   assign right    = right_r;
   assign up       = up_r;
   assign down     = down_r;

   // Next slot contents: clear, then load (may reuse a retiring slot), retire, scroll.
   always_comb begin
      valid_s = valid_r;
      left_s  = left_r;
      right_s = right_r;
      up_s    = up_r;
      down_s  = down_r;
      if (clear || (step && !load && retire_s)) begin
         valid_s = 1'b0;
         left_s  = 10'd0;
         right_s = 10'd0;
         up_s    = 9'd0;
         down_s  = 9'd0;
      end else if (step && load) begin
         valid_s = 1'b1;
         left_s  = SCREEN_W;
         right_s = SCREEN_W + OBS_W;
         up_s    = load_up;
         down_s  = load_up + OBS_H;
      end else if (step && valid_r) begin
         left_s  = sat_sub_x(left_r, STEP_X);
         right_s = right_r - STEP_X;
      end else begin
         valid_s = valid_r;
         left_s  = left_r;
      end
   end

   // Slot state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 1'b0;
         left_r  <= 10'd0;
         right_r <= 10'd0;
         up_r    <= 9'd0;
         down_r  <= 9'd0;
      end else begin
         valid_r <= valid_s;
         left_r  <= left_s;
         right_r <= right_s;
         up_r    <= up_s;
         down_r  <= down_s;
      end
   end

endmodule

// File: rtl/game_ctrl.sv
// Frame-rate game sequencer: mode FSM, player motion, obstacle spawning,
// collision detection and score. Everything advances on frame_tick only.
module game_ctrl
   import game_pkg::*;
#(
   parameter int unsigned N_OBS        = 10,
   parameter int unsigned SPAWN_PERIOD = 60,
   parameter int unsigned SCROLL_STEP  = 2,
   parameter int unsigned JUMP_STEP    = 4,
   parameter int unsigned FALL_STEP    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_tick,
   input  logic                  btn_start,
   input  logic                  btn_pause,
   input  logic                  btn_jump,
   input  logic [8:0]            rnd,
   output logic [1:0]            gamemode,
   output logic [8:0]            player_y,
   output logic [N_OBS-1:0][9:0] obstacle_x_game_left,
   output logic [N_OBS-1:0][9:0] obstacle_x_game_right,
   output logic [N_OBS-1:0][8:0] obstacle_y_game_up,
   output logic [N_OBS-1:0][8:0] obstacle_y_game_down,
   output logic [15:0]           score
);

   localparam int unsigned CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
   localparam int unsigned RET_W = $clog2(N_OBS + 1);
   localparam logic [8:0]  Y_MAX = SCREEN_H - PLAYER_H;
   localparam logic [8:0]  JUMP_Y = 9'(JUMP_STEP);
   localparam logic [8:0]  FALL_Y = 9'(FALL_STEP);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);

   gamemode_t        state_r, state_s;
   logic [8:0]       player_y_r, player_y_s;
   logic [15:0]      score_r, score_s;
   logic [CNT_W-1:0] spawn_cnt_r, spawn_cnt_s;

   logic [N_OBS-1:0] free_s, retire_s, hit_s, load_s;
   logic             hit_any_s, clear_s, step_s, spawn_s, taken_s;
   logic [RET_W-1:0] retire_cnt_s;
   logic [16:0]      score_sum_s;
   logic [8:0]       load_up_s;
   logic             unused_rnd_s;

   assign unused_rnd_s = rnd[8];
   assign load_up_s    = {1'b0, rnd[7:0]} + 9'd32;
   assign hit_any_s    = |hit_s;
   assign clear_s      = (state_r == GM_START) && btn_start;
   assign step_s       = (state_r == GM_GAME) && frame_tick && !hit_any_s;
   assign spawn_s      = step_s && (spawn_cnt_r == CNT_LAST);

   for (genvar g = 0; g < N_OBS; g++) begin : g_slot
      obstacle_slot #(
         .SCROLL_STEP(SCROLL_STEP)
      ) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .clear    (clear_s),
         .step     (step_s),
         .load     (load_s[g]),
         .load_up  (load_up_s),
         .player_y (player_y_r),
         .free     (free_s[g]),
         .retire   (retire_s[g]),
         .hit      (hit_s[g]),
         .left     (obstacle_x_game_left[g]),
         .right    (obstacle_x_game_right[g]),
         .up       (obstacle_y_game_up[g]),
         .down     (obstacle_y_game_down[g])
      );
   end

   // Lowest-free priority encoder and retire count; a full table drops the spawn.
   always_comb begin
      load_s       = '0;
      taken_s      = 1'b0;
      retire_cnt_s = '0;
      for (int i = 0; i < N_OBS; i++) begin
         if (free_s[i] && !taken_s) begin
            load_s[i] = spawn_s;
            taken_s   = 1'b1;
         end else begin
            load_s[i] = 1'b0;
         end
         retire_cnt_s = retire_cnt_s + RET_W'(retire_s[i]);
      end
   end

   // Mode FSM: a collision on the tick outranks a simultaneous pause.
   always_comb begin
      state_s = state_r;
      case (state_r)
         GM_START: begin
            if (btn_start) state_s = GM_GAME;
            else           state_s = GM_START;
         end
         GM_GAME: begin
            if (frame_tick && hit_any_s) state_s = GM_END;
            else if (btn_pause)          state_s = GM_PAUSE;
            else                         state_s = GM_GAME;
         end
         GM_PAUSE: begin
            if (btn_pause) state_s = GM_GAME;
            else           state_s = GM_PAUSE;
         end
         GM_END: begin
            if (btn_start) state_s = GM_START;
            else           state_s = GM_END;
         end
         default: state_s = GM_START;
      endcase
   end

   // Player, spawn counter and score; all hold unless clearing or stepping.
   always_comb begin
      player_y_s  = player_y_r;
      spawn_cnt_s = spawn_cnt_r;
      score_s     = score_r;
      score_sum_s = {1'b0, score_r} + 17'(retire_cnt_s);
      if (clear_s) begin
         player_y_s  = PLAYER_Y0;
         spawn_cnt_s = '0;
         score_s     = 16'd0;
      end else if (step_s) begin
         if (btn_jump) player_y_s = sat_sub_y(player_y_r, JUMP_Y);
         else          player_y_s = sat_add_y(player_y_r, FALL_Y, Y_MAX);
         if (spawn_s)  spawn_cnt_s = '0;
         else          spawn_cnt_s = spawn_cnt_r + CNT_W'(1);
         score_s = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
      end else begin
         player_y_s = player_y_r;
      end
   end

   // Top-level state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= GM_START;
         player_y_r  <= PLAYER_Y0;
         score_r     <= 16'd0;
         spawn_cnt_r <= '0;
      end else begin
         state_r     <= state_s;
         player_y_r  <= player_y_s;
         score_r     <= score_s;
         spawn_cnt_r <= spawn_cnt_s;
      end
   end

   assign gamemode = state_r;
   assign player_y = player_y_r;
   assign score    = score_r;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed plus randomized bench for game_ctrl; a frame-level reference model
// (plain integers, one function per frame) predicts every output each cycle.
`timescale 1ns/1ps
module tb_game_ctrl;

   localparam int NS = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                ft_a, bs_a, bp_a, bj_a, ft_b, bs_b, bp_b, bj_b;
   logic [8:0]          rnd_a, rnd_b, py_a, py_b;
   logic [1:0]          gm_a, gm_b;
   logic [15:0]         sc_a, sc_b;
   logic [NS-1:0][9:0]  xl_a, xr_a, xl_b, xr_b;
   logic [NS-1:0][8:0]  yu_a, yd_a, yu_b, yd_b;

   game_ctrl dut_a (
      .clk(clk), .rst_n(rst_n), .frame_tick(ft_a), .btn_start(bs_a), .btn_pause(bp_a),
      .btn_jump(bj_a), .rnd(rnd_a), .gamemode(gm_a), .player_y(py_a),
      .obstacle_x_game_left(xl_a), .obstacle_x_game_right(xr_a),
      .obstacle_y_game_up(yu_a), .obstacle_y_game_down(yd_a), .score(sc_a)
   );

   game_ctrl #(.SPAWN_PERIOD(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .frame_tick(ft_b), .btn_start(bs_b), .btn_pause(bp_b),
      .btn_jump(bj_b), .rnd(rnd_b), .gamemode(gm_b), .player_y(py_b),
      .obstacle_x_game_left(xl_b), .obstacle_x_game_right(xr_b),
      .obstacle_y_game_up(yu_b), .obstacle_y_game_down(yd_b), .score(sc_b)
   );

   typedef struct {
      int mode;
      int py;
      int score;
      int cnt;
      bit v [NS];
      int l [NS];
      int r [NS];
      int u [NS];
      int d [NS];
   } model_t;

   model_t ma, mb, ms;
   int     tests = 0;
   int     fails = 0;
   bit     coll_seen;
   int     nvalid;

   function automatic model_t m_reset();
      model_t m;
      m.mode = 0; m.py = 200; m.score = 0; m.cnt = 0;
      for (int i = 0; i < NS; i++) begin
         m.v[i] = 1'b0; m.l[i] = 0; m.r[i] = 0; m.u[i] = 0; m.d[i] = 0;
      end
      return m;
   endfunction

   function automatic bit m_hit(model_t m);
      bit h = 1'b0;
      for (int i = 0; i < NS; i++)
         if (m.v[i] && m.l[i] < 100 && m.r[i] > 80 && m.u[i] < m.py + 20 && m.d[i] > m.py)
            h = 1'b1;
      return h;
   endfunction

   // One clock of the game as the rules describe it.
   function automatic model_t m_step(model_t m, int period, bit tick, bit start,
                                     bit pause, bit jump, int rv);
      model_t n = m;
      bit     hit = (m.mode == 1) && tick && m_hit(m);
      bit     placed = 1'b0;
      case (m.mode)
         0: if (start) begin n = m_reset(); n.mode = 1; end
         1: begin
            if (hit) n.mode = 3;
            else begin
               if (pause) n.mode = 2;
               if (tick) begin
                  if (jump) n.py = (m.py < 4) ? 0 : m.py - 4;
                  else      n.py = (m.py + 2 > 460) ? 460 : m.py + 2;
                  for (int i = 0; i < NS; i++) begin
                     if (n.v[i] && n.r[i] > 2) begin
                        n.l[i] = (n.l[i] > 2) ? n.l[i] - 2 : 0;
                        n.r[i] = n.r[i] - 2;
                     end else if (n.v[i]) begin
                        n.v[i] = 1'b0; n.l[i] = 0; n.r[i] = 0; n.u[i] = 0; n.d[i] = 0;
                        if (n.score < 65535) n.score = n.score + 1;
                     end
                  end
                  if (m.cnt == period - 1) begin
                     n.cnt = 0;
                     for (int i = 0; i < NS; i++) begin
                        if (!n.v[i] && !placed) begin
                           placed = 1'b1;
                           n.v[i] = 1'b1; n.l[i] = 640; n.r[i] = 680;
                           n.u[i] = (rv & 255) + 32; n.d[i] = n.u[i] + 120;
                        end
                     end
                  end else begin
                     n.cnt = m.cnt + 1;
                  end
               end
            end
         end
         2: if (pause) n.mode = 1;
         3: if (start) n.mode = 0;
         default: n.mode = 0;
      endcase
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_dut(input string who, input model_t m, input logic [1:0] gm,
                          input logic [8:0] py, input logic [15:0] sc,
                          input logic [NS-1:0][9:0] xl, input logic [NS-1:0][9:0] xr,
                          input logic [NS-1:0][8:0] yu, input logic [NS-1:0][8:0] yd);
      chk({who, ".mode"}, 32'(gm), m.mode);
      chk({who, ".player_y"}, 32'(py), m.py);
      chk({who, ".score"}, 32'(sc), m.score);
      for (int i = 0; i < NS; i++) begin
         chk($sformatf("%s.left[%0d]", who, i), 32'(xl[i]), m.l[i]);
         chk($sformatf("%s.right[%0d]", who, i), 32'(xr[i]), m.r[i]);
         chk($sformatf("%s.up[%0d]", who, i), 32'(yu[i]), m.u[i]);
         chk($sformatf("%s.down[%0d]", who, i), 32'(yd[i]), m.d[i]);
      end
   endtask

   task automatic cyc_a(input bit tick, input bit start, input bit pause, input bit jump,
                        input int rv);
      ft_a = tick; bs_a = start; bp_a = pause; bj_a = jump; rnd_a = 9'(rv);
      @(posedge clk); #1;
      ma = m_step(ma, 60, tick, start, pause, jump, rv);
      ft_a = 1'b0; bs_a = 1'b0; bp_a = 1'b0;
      chk_dut("A", ma, gm_a, py_a, sc_a, xl_a, xr_a, yu_a, yd_a);
   endtask

   task automatic cyc_b(input bit tick, input bit start, input bit pause, input bit jump,
                        input int rv);
      ft_b = tick; bs_b = start; bp_b = pause; bj_b = jump; rnd_b = 9'(rv);
      @(posedge clk); #1;
      mb = m_step(mb, 4, tick, start, pause, jump, rv);
      ft_b = 1'b0; bs_b = 1'b0; bp_b = 1'b0;
      chk_dut("B", mb, gm_b, py_b, sc_b, xl_b, xr_b, yu_b, yd_b);
   endtask

   initial begin
      ft_a = 1'b0; bs_a = 1'b0; bp_a = 1'b0; bj_a = 1'b0; rnd_a = 9'd0;
      ft_b = 1'b0; bs_b = 1'b0; bp_b = 1'b0; bj_b = 1'b0; rnd_b = 9'd0;
      ma = m_reset();
      mb = m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_dut("A.rst", ma, gm_a, py_a, sc_a, xl_a, xr_a, yu_a, yd_a);
      chk_dut("B.rst", mb, gm_b, py_b, sc_b, xl_b, xr_b, yu_b, yd_b);
      rst_n = 1'b1;

      // Reset and start
      cyc_a(1'b0, 1'b1, 1'b0, 1'b0, 16);
      chk("start.mode", 32'(gm_a), 1);
      chk("start.player_y", 32'(py_a), 200);
      chk("start.score", 32'(sc_a), 0);

      // Spawn on the 60th tick, then scroll
      for (int k = 0; k < 60; k++) cyc_a(1'b1, 1'b0, 1'b0, k[0], 16);
      chk("spawn.left0", 32'(xl_a[0]), 640);
      chk("spawn.right0", 32'(xr_a[0]), 680);
      chk("spawn.up0", 32'(yu_a[0]), 48);
      chk("spawn.down0", 32'(yd_a[0]), 168);
      for (int k = 0; k < 10; k++) cyc_a(1'b1, 1'b0, 1'b0, k[0], 16);
      chk("scroll.left0", 32'(xl_a[0]), 620);

      // Pause freezes everything; start is ignored while paused
      cyc_a(1'b0, 1'b0, 1'b1, 1'b0, 16);
      chk("pause.mode", 32'(gm_a), 2);
      ms = ma;
      for (int k = 0; k < 20; k++)
         cyc_a(1'b1, k == 5, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 511)));
      chk_dut("pause.hold", ms, gm_a, py_a, sc_a, xl_a, xr_a, yu_a, yd_a);
      cyc_a(1'b0, 1'b0, 1'b1, 1'b0, 16);
      chk("resume.mode", 32'(gm_a), 1);

      // Player saturation at both ends
      repeat (60) cyc_a(1'b1, 1'b0, 1'b0, 1'b1, 16);
      chk("sat.top", 32'(py_a), 0);
      repeat (300) cyc_a(1'b1, 1'b0, 1'b0, 1'b0, 16);
      chk("sat.bottom", 32'(py_a), 460);

      // Steer into the obstacle band; collision wins over a same-cycle pause
      coll_seen = 1'b0;
      for (int k = 0; k < 400 && !coll_seen; k++) begin
         if (m_hit(ma)) begin
            ms = ma;
            cyc_a(1'b1, 1'b0, 1'b1, 1'b0, 16);
            chk("coll.mode", 32'(gm_a), 3);
            chk("coll.player_y", 32'(py_a), ms.py);
            for (int i = 0; i < NS; i++)
               chk($sformatf("coll.left[%0d]", i), 32'(xl_a[i]), ms.l[i]);
            coll_seen = 1'b1;
         end else begin
            cyc_a(1'b1, 1'b0, 1'b0, ma.py > 100, 16);
         end
      end
      chk("coll.seen", 32'(coll_seen), 1);
      repeat (5) cyc_a(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 16);
      cyc_a(1'b0, 1'b0, 1'b1, 1'b0, 16);
      chk("end.pause_ignored", 32'(gm_a), 3);
      cyc_a(1'b0, 1'b1, 1'b0, 1'b0, 16);
      chk("end.to_start", 32'(gm_a), 0);
      cyc_a(1'b0, 1'b1, 1'b0, 1'b0, 16);
      chk("restart.mode", 32'(gm_a), 1);
      chk("restart.right0", 32'(xr_a[0]), 0);

      // Random play on A
      for (int k = 0; k < 1500; k++)
         cyc_a($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
               $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 511)));

      // Full table on B (spawn every 4 frames)
      cyc_b(1'b0, 1'b1, 1'b0, 1'b0, 0);
      chk("B.start.mode", 32'(gm_b), 1);
      for (int k = 0; k < 40; k++) cyc_b(1'b1, 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 511)));
      nvalid = 0;
      for (int i = 0; i < NS; i++) if (xr_b[i] != 10'd0) nvalid++;
      chk("full.count", 32'(nvalid), 10);
      for (int k = 0; k < 4; k++) cyc_b(1'b1, 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 511)));
      chk("full.left0", 32'(xl_b[0]), 560);
      chk("full.left9", 32'(xl_b[9]), 632);
      for (int k = 0; k < 500; k++)
         cyc_b($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
               $urandom_range(0, 49) == 0, 1'b0, int'($urandom_range(0, 511)));
      if (mb.mode == 2) cyc_b(1'b0, 1'b0, 1'b1, 1'b0, 0);
      chk("B.running", 32'(gm_b), 1);
      for (int k = 0; k < 400; k++) cyc_b(1'b1, 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 511)));
      chk("B.retired", 32'(sc_b != 16'd0), 1);

      // Reset asserted mid-cycle acts immediately
      #2 rst_n = 1'b0;
      #1;
      ma = m_reset();
      mb = m_reset();
      chk_dut("A.midrst", ma, gm_a, py_a, sc_a, xl_a, xr_a, yu_a, yd_a);
      chk_dut("B.midrst", mb, gm_b, py_b, sc_b, xl_b, xr_b, yu_b, yd_b);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc_a(1'b0, 1'b1, 1'b0, 1'b0, 0);
      chk("post_rst.mode", 32'(gm_a), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
